// File: rtl/slave_port_pkg.sv
// rtl/slave_port_pkg.sv - shared state type and helpers for burst_slave_port
//
// Contents:
//   state_e      FSM state encoding; ST_SPLIT exists only with SLAVE_PORT_SPLIT_EN
//   cnt_width()  bit counter width for the longest serial field
//   is_serial()  states in which the port accepts serial transfers
package slave_port_pkg;

  typedef enum logic [2:0] {
    ST_ADDR  = 3'd0,
    ST_LEN   = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_RDATA = 3'd5
`ifdef SLAVE_PORT_SPLIT_EN
    , ST_SPLIT = 3'd6
`endif
  } state_e;

  // Wide enough to count up to the longest of the three serial fields.
  function automatic int cnt_width(input int a, input int l, input int d);
    int m;
    m = a;
    if (l > m) m = l;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

  function automatic logic is_serial(input state_e s);
    return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_WDATA) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// rtl/ser_shift_reg.sv - serial-in/serial-out shift register with parallel load
//
// Shifts right: the serial input enters at the MSB, so after W shifts the
// first (LSB-first) bit sits at bit 0. Load has priority over shift.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   shift_i        shift one position right, ser_i into MSB
//   ser_i          serial input bit
//   load_i         load data_i in parallel
//   data_i [W]     parallel load value
//   q_o    [W]     current register contents
//   nxt_o  [W]     contents after a shift this cycle (lets the caller use the
//                  complete word on the edge that captures its last bit)
//   ser_o          LSB of the register (serial output)
module ser_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         shift_i,
  input  logic         ser_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] nxt_o,
  output logic         ser_o
);

  logic [W-1:0] sr_q, sr_d;
  logic [W-1:0] shifted;

  // Written with shifts rather than slices so W=1 stays legal.
  assign shifted = (W'(ser_i) << (W - 1)) | (sr_q >> 1);

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o   = sr_q;
  assign nxt_o = shifted;
  assign ser_o = sr_q[0];

endmodule

// File: rtl/burst_slave_port.sv
// rtl/burst_slave_port.sv - bit-serial bus slave port issuing parallel burst requests
//
// Optional feature macro: SLAVE_PORT_SPLIT_EN (split read transactions).
//
// Ports:
//   in_clk, reset_n        bus clock, asynchronous active-low reset
//   ss                     slave select
//   ser_in_valid_ready     master valid (RX) / master ready (TX)
//   in_write, burst_en     direction / burst request, sampled with address bit 0
//   in_addr                serial address then length, LSB first
//   ser_wdata              serial write data, LSB first
//   par_in_valid_ready     target accept (write) / data valid (read)
//   par_rdata [DATA_W]     target read data
//   in_split_en            target split request
//   ser_out_valid_ready    port ready (RX) / port valid (TX)
//   ser_rdata              serial read data, LSB first
//   out_split_en           split in progress, bus released
//   par_out_valid_ready    parallel request pending
//   out_write              request direction
//   out_addr  [ADDR_W]     request address
//   par_wdata [DATA_W]     request write data
//   out_clk                copy of in_clk
module burst_slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              in_clk,
  input  logic              reset_n,
  input  logic              ss,
  input  logic              ser_in_valid_ready,
  input  logic              in_write,
  input  logic              burst_en,
  input  logic              in_addr,
  input  logic              ser_wdata,
  input  logic              par_in_valid_ready,
  input  logic [DATA_W-1:0] par_rdata,
  input  logic              in_split_en,
  output logic              ser_out_valid_ready,
  output logic              ser_rdata,
  output logic              out_split_en,
  output logic              par_out_valid_ready,
  output logic              out_write,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] par_wdata,
  output logic              out_clk
);

  localparam int CNT_W = cnt_width(ADDR_W, LEN_W, DATA_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]  beats_q, beats_d;      // beats still to go after the current one
  logic [ADDR_W-1:0] addr_q, addr_d;        // address of the current/next beat
  logic              write_q, write_d;
  logic              burst_q, burst_d;
  logic              ser_ovr_q, ser_ovr_d;
  logic              pvr_q, pvr_d;
  logic              out_write_q, out_write_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef SLAVE_PORT_SPLIT_EN
  logic              split_q, split_d;
`endif

  logic              xfer;
  logic              hs;
  logic              serial_q;
  logic              tx_load;
  logic              write_cur;
  logic              burst_cur;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LEN_W-1:0]  len_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  logic [ADDR_W-1:0] unused_addr_q;
  logic [LEN_W-1:0]  unused_len_q;
  logic [DATA_W-1:0] unused_wdata_q;
  logic [DATA_W-1:0] unused_tx_q;
  logic [DATA_W-1:0] unused_tx_nxt;
  logic              unused_addr_ser;
  logic              unused_len_ser;
  logic              unused_wdata_ser;

  assign xfer     = ss && ser_in_valid_ready && ser_ovr_q;
  assign hs       = pvr_q && par_in_valid_ready;
  assign serial_q = is_serial(state_q);

  // Direction and burst flag are sampled with address bit 0; on that very
  // edge the registered copy is not yet valid, so take the live input.
  assign write_cur = (bit_cnt_q == '0) ? in_write : write_q;
  assign burst_cur = (bit_cnt_q == '0) ? burst_en : burst_q;

  ser_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk_i   (in_clk),
    .rst_ni  (reset_n),
    .shift_i (xfer && (state_q == ST_ADDR)),
    .ser_i   (in_addr),
    .load_i  (1'b0),
    .data_i  ('0),
    .q_o     (unused_addr_q),
    .nxt_o   (addr_nxt),
    .ser_o   (unused_addr_ser)
  );

  ser_shift_reg #(.W(LEN_W)) u_len_sr (
    .clk_i   (in_clk),
    .rst_ni  (reset_n),
    .shift_i (xfer && (state_q == ST_LEN)),
    .ser_i   (in_addr),
    .load_i  (1'b0),
    .data_i  ('0),
    .q_o     (unused_len_q),
    .nxt_o   (len_nxt),
    .ser_o   (unused_len_ser)
  );

  ser_shift_reg #(.W(DATA_W)) u_wdata_sr (
    .clk_i   (in_clk),
    .rst_ni  (reset_n),
    .shift_i (xfer && (state_q == ST_WDATA)),
    .ser_i   (ser_wdata),
    .load_i  (1'b0),
    .data_i  ('0),
    .q_o     (unused_wdata_q),
    .nxt_o   (wdata_nxt),
    .ser_o   (unused_wdata_ser)
  );

  ser_shift_reg #(.W(DATA_W)) u_tx_sr (
    .clk_i   (in_clk),
    .rst_ni  (reset_n),
    .shift_i (xfer && (state_q == ST_RDATA)),
    .ser_i   (1'b0),
    .load_i  (tx_load),
    .data_i  (par_rdata),
    .q_o     (unused_tx_q),
    .nxt_o   (unused_tx_nxt),
    .ser_o   (ser_rdata)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    beats_d     = beats_q;
    addr_d      = addr_q;
    write_d     = write_q;
    burst_d     = burst_q;
    pvr_d       = pvr_q;
    out_write_d = out_write_q;
    out_addr_d  = out_addr_q;
    wdata_d     = wdata_q;
    tx_load     = 1'b0;
`ifdef SLAVE_PORT_SPLIT_EN
    split_d     = split_q;
`endif

    if (serial_q && !ss) begin
      // Deselect abandons the serial phase; an issued request stays pending.
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      beats_d   = '0;
    end else begin
      if (xfer) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end

      case (state_q)
        ST_ADDR: begin
          if (xfer) begin
            if (bit_cnt_q == '0) begin
              write_d = in_write;
              burst_d = burst_en;
            end
            if (bit_cnt_q == ADDR_LAST) begin
              addr_d  = addr_nxt;
              beats_d = '0;
              if (burst_cur) begin
                state_d = ST_LEN;
              end else if (write_cur) begin
                state_d = ST_WDATA;
              end else begin
                state_d     = ST_READ;
                pvr_d       = 1'b1;
                out_write_d = 1'b0;
                out_addr_d  = addr_nxt;
              end
            end
          end
        end

        ST_LEN: begin
          if (xfer && (bit_cnt_q == LEN_LAST)) begin
            beats_d = len_nxt;
            if (write_q) begin
              state_d = ST_WDATA;
            end else begin
              state_d     = ST_READ;
              pvr_d       = 1'b1;
              out_write_d = 1'b0;
              out_addr_d  = addr_q;
            end
          end
        end

        ST_WDATA: begin
          if (xfer && (bit_cnt_q == DATA_LAST)) begin
            state_d     = ST_WRITE;
            pvr_d       = 1'b1;
            out_write_d = 1'b1;
            out_addr_d  = addr_q;
            wdata_d     = wdata_nxt;
          end
        end

        ST_WRITE: begin
          if (hs) begin
            pvr_d  = 1'b0;
            addr_d = addr_q + ADDR_W'(1);
            if (beats_q != '0) begin
              beats_d = beats_q - LEN_W'(1);
              state_d = ST_WDATA;
            end else begin
              state_d = ST_ADDR;
            end
          end
        end

        ST_READ: begin
          if (hs) begin
            pvr_d   = 1'b0;
            tx_load = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_RDATA;
          end
`ifdef SLAVE_PORT_SPLIT_EN
          else if (in_split_en) begin
            state_d = ST_SPLIT;
            split_d = 1'b1;
          end
`endif
        end

`ifdef SLAVE_PORT_SPLIT_EN
        // The request stays pending while the bus is released; ss is not
        // looked at here because SPLIT is not a serial state.
        ST_SPLIT: begin
          if (hs) begin
            pvr_d   = 1'b0;
            tx_load = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            split_d = 1'b0;
            state_d = ST_RDATA;
          end
        end
`endif

        ST_RDATA: begin
          if (xfer && (bit_cnt_q == DATA_LAST)) begin
            if (beats_q != '0) begin
              beats_d     = beats_q - LEN_W'(1);
              state_d     = ST_READ;
              pvr_d       = 1'b1;
              out_write_d = 1'b0;
              out_addr_d  = addr_q;
            end else begin
              state_d = ST_ADDR;
            end
          end
        end

        default: begin
          state_d = ST_ADDR;
        end
      endcase
    end

    if (state_d != state_q) begin
      bit_cnt_d = '0;
    end

    ser_ovr_d = is_serial(state_d);
  end

  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ADDR;
      bit_cnt_q   <= '0;
      beats_q     <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      burst_q     <= 1'b0;
      ser_ovr_q   <= 1'b0;
      pvr_q       <= 1'b0;
      out_write_q <= 1'b0;
      out_addr_q  <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      beats_q     <= beats_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      burst_q     <= burst_d;
      ser_ovr_q   <= ser_ovr_d;
      pvr_q       <= pvr_d;
      out_write_q <= out_write_d;
      out_addr_q  <= out_addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef SLAVE_PORT_SPLIT_EN
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      split_q <= 1'b0;
    end else begin
      split_q <= split_d;
    end
  end
  assign out_split_en = split_q;
`else
  logic unused_split_en;
  assign unused_split_en = in_split_en;
  assign out_split_en    = 1'b0;
`endif

  assign ser_out_valid_ready = ser_ovr_q;
  assign par_out_valid_ready = pvr_q;
  assign out_write           = out_write_q;
  assign out_addr            = out_addr_q;
  assign par_wdata           = wdata_q;
  assign out_clk             = in_clk;

endmodule
